// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, index type and circular first-one search for the mux arbiter.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
// Contents: MUX_ARB_N / MUX_ARB_W defaults, idx_t, first_one_circ().
package mux_arb_pkg;

  localparam int MUX_ARB_N = 4;
  localparam int MUX_ARB_W = 8;

  typedef logic [$clog2(MUX_ARB_N)-1:0] idx_t;

  // Index of the first set bit of req[0..n-1], searching upward from start and
  // wrapping past n-1 to 0; -1 when no bit is set. The loop runs downward so
  // the last hit written is the one nearest to start, which avoids a break.
  // n must be a constant no larger than 32 and start must be below n.
  function automatic int first_one_circ(input logic [31:0] req, input int n, input int start);
    int i;
    int res;
    res = -1;
    for (int k = 31; k >= 0; k--) begin
      if (k < n) begin
        i = start + k;
        if (i >= n) i = i - n;
        if (req[i]) res = i;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester and consumer signals of the shared-output arbiter, grouped as one bundle.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; in_ready is one-hot or zero.
// Modports: slave = arbiter side, master = requesters plus consumer side.
interface mux_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]         in_valid;
  logic [N*W-1:0]       in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic                 out_ready;
  logic [$clog2(N)-1:0] out_src;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_rr_arbiter_arb_pick.sv
// Combinational circular priority pick: first set req bit at or after start.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; found=0 when no request is set.
// Ports: req[N], start -> found, idx.
module arb_pick
  import mux_arb_pkg::*;
#(
  parameter int N = MUX_ARB_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  logic [31:0] req32;
  int          res;

  always_comb begin
    req32        = '0;
    req32[N-1:0] = req;
    res          = first_one_circ(req32, N, int'(start));
    found        = (res >= 0);
    idx          = IW'(res);
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering N valid/ready requesters into one output register.
// Latency: word accepted at edge k is on out_data/out_valid right after edge k.
// Backpressure: loads only when out is empty or being taken; otherwise in_ready=0 and out holds.
// Ports: clk, rst (sync, active-high), bus (slave modport of mux_rr_arbiter_if).
// Build option: MUX_ARB_FIXED_PRIORITY_EN selects lowest-index-wins and drops the pointer.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = MUX_ARB_N,
  parameter int W = MUX_ARB_W
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);
  localparam int IW = $clog2(N);

  logic          load;
  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] start;

  // Register can take a new word when empty or when the consumer drains it
  // this same cycle, so handshake-out and load-in overlap without a bubble.
  assign load = !bus.out_valid || bus.out_ready;

`ifdef MUX_ARB_FIXED_PRIORITY_EN
  assign start = '0;
`else
  logic [IW-1:0] ptr;

  assign start = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && found) begin
      ptr <= (int'(win) == N-1) ? '0 : win + 1'b1;
    end
  end
`endif

  arb_pick #(.N(N)) u_pick (
    .req   (bus.in_valid),
    .start (start),
    .found (found),
    .idx   (win)
  );

  // Grant is suppressed during reset so no handshake is seen that cycle.
  always_comb begin
    bus.in_ready = '0;
    if (!rst && load && found) bus.in_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (load) begin
      if (found) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.in_data[win*W +: W];
        bus.out_src   <= win;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
